// File: rtl/auth_req_tracker_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | auth_req_tracker_if : request, message, response and timeout-control bus     |
// | Optional stat_* signals exist only when AUTH_TRK_STATS_EN is defined.        |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface auth_req_tracker_if #(
  parameter int TMO_W = 32
);
  logic             req_valid;
  logic [1:0]       req_type;
  logic             req_ready;
  logic             abort;
  logic             msg_send;
  logic [1:0]       msg_type;
  logic             resp_valid;
  logic             resp_is_error;
  logic             tmo_enable;
  logic             tmo_clear;
  logic [TMO_W-1:0] tmo_value;
  logic             tmo_expired;
  logic             done;
  logic [1:0]       done_status;
  logic [2:0]       retry_cnt;
`ifdef AUTH_TRK_STATS_EN
  logic [15:0]      stat_timeouts;
  logic [15:0]      stat_resends;

  modport master (
    input  req_valid, req_type, abort, resp_valid, resp_is_error, tmo_expired,
    output req_ready, msg_send, msg_type, tmo_enable, tmo_clear, tmo_value,
    output done, done_status, retry_cnt, stat_timeouts, stat_resends
  );
  modport slave (
    output req_valid, req_type, abort, resp_valid, resp_is_error, tmo_expired,
    input  req_ready, msg_send, msg_type, tmo_enable, tmo_clear, tmo_value,
    input  done, done_status, retry_cnt, stat_timeouts, stat_resends
  );
`else
  modport master (
    input  req_valid, req_type, abort, resp_valid, resp_is_error, tmo_expired,
    output req_ready, msg_send, msg_type, tmo_enable, tmo_clear, tmo_value,
    output done, done_status, retry_cnt
  );
  modport slave (
    output req_valid, req_type, abort, resp_valid, resp_is_error, tmo_expired,
    input  req_ready, msg_send, msg_type, tmo_enable, tmo_clear, tmo_value,
    input  done, done_status, retry_cnt
  );
`endif
endinterface
`default_nettype wire

// File: rtl/auth_req_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | auth_req_tracker : issues one auth request, drives the timeout block,        |
// | retries on expiry, reports one final status. Option: AUTH_TRK_STATS_EN.      |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module auth_req_tracker #(
  parameter int TMO_W         = 32,
  parameter int TMO_DIGESTS   = 1000,
  parameter int TMO_CERT      = 4000,
  parameter int TMO_CHALLENGE = 2000,
  parameter int MAX_RETRIES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  auth_req_tracker_if.master  bus
);

  localparam logic [2:0] MAX_R       = 3'(MAX_RETRIES);
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_ABORT    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_RETRY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] typ;
  logic [2:0] retries;
  logic [1:0] status;
  logic [1:0] status_nx;
  logic       first_wait;
  logic       accept;
  logic       resend;
  logic       retry_entry;
  logic       timeout_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    status_nx       = status;
    accept          = 1'b0;
    resend          = 1'b0;
    retry_entry     = 1'b0;
    timeout_done    = 1'b0;
    bus.req_ready   = 1'b0;
    bus.msg_send    = 1'b0;
    bus.tmo_enable  = 1'b0;
    bus.tmo_clear   = 1'b0;
    bus.done        = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = S_SEND;
        end
      end
      S_SEND: begin
        bus.msg_send = 1'b1;
        state_nx     = S_WAIT;
      end
      S_WAIT: begin
        bus.tmo_enable = 1'b1;
        bus.tmo_clear  = bus.resp_valid;
        if (bus.abort) begin
          status_nx = ST_ABORT;
          state_nx  = S_DONE;
        end else if (bus.resp_valid) begin
          status_nx = bus.resp_is_error ? 2'b01 : ST_OK;
          state_nx  = S_DONE;
        // The downstream expiry flag is registered, so on the first WAIT cycle
        // it still reflects the previous attempt and must be ignored.
        end else if (bus.tmo_expired && !first_wait) begin
          if (retries < MAX_R) begin
            retry_entry = 1'b1;
            state_nx    = S_RETRY;
          end else begin
            timeout_done = 1'b1;
            status_nx    = ST_TIMEOUT;
            state_nx     = S_DONE;
          end
        end
      end
      S_RETRY: begin
        if (bus.abort) begin
          status_nx = ST_ABORT;
          state_nx  = S_DONE;
        end else begin
          resend   = 1'b1;
          state_nx = S_SEND;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      typ        <= 2'b00;
      retries    <= 3'd0;
      status     <= ST_OK;
      first_wait <= 1'b0;
    end else begin
      status     <= status_nx;
      first_wait <= (state == S_SEND);
      if (accept) begin
        typ     <= bus.req_type;
        retries <= 3'd0;
      end else if (resend) begin
        retries <= retries + 3'd1;
      end
    end
  end

  always_comb begin
    case (typ)
      2'b00:   bus.tmo_value = TMO_W'(TMO_DIGESTS);
      2'b01:   bus.tmo_value = TMO_W'(TMO_CERT);
      default: bus.tmo_value = TMO_W'(TMO_CHALLENGE);
    endcase
  end

  assign bus.msg_type    = typ;
  assign bus.done_status = status;
  assign bus.retry_cnt   = retries;

`ifdef AUTH_TRK_STATS_EN
  logic [15:0] stat_to;
  logic [15:0] stat_rs;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_to <= 16'h0000;
      stat_rs <= 16'h0000;
    end else begin
      if (timeout_done && (stat_to != 16'hFFFF)) begin
        stat_to <= stat_to + 16'h0001;
      end
      if (retry_entry && (stat_rs != 16'hFFFF)) begin
        stat_rs <= stat_rs + 16'h0001;
      end
    end
  end

  assign bus.stat_timeouts = stat_to;
  assign bus.stat_resends  = stat_rs;
`endif

endmodule
`default_nettype wire
